// File: rtl/dm_bus_responder_pkg.sv
// Shared types for the data-memory responder.
// Access-size encodings and FSM state type.
package dm_bus_responder_pkg;

  localparam logic [1:0] DM_ALIGN_WORD = 2'd0;
  localparam logic [1:0] DM_ALIGN_HALF = 2'd1;
  localparam logic [1:0] DM_ALIGN_BYTE = 2'd2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dm_state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/half/word lane steering for the responder.
// Store merge into the old word and load extract with extension.
module dm_lane_unit
  import dm_bus_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  align,
  input  logic        sign,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {addr_lo, 3'b000};
  assign hsh = {addr_lo[1], 4'b0000};
  assign b   = old_word[bsh +: 8];
  assign h   = old_word[hsh +: 16];

  // merge store data into the lanes it covers, extract load lanes
  always_comb begin
    new_word = old_word;
    rdata    = '0;
    case (align)
      DM_ALIGN_BYTE: begin
        new_word[bsh +: 8] = wdata[7:0];
        rdata = {{24{sign & b[7]}}, b};
      end
      DM_ALIGN_HALF: begin
        new_word[hsh +: 16] = wdata[15:0];
        rdata = {{16{sign & h[15]}}, h};
      end
      DM_ALIGN_WORD: begin
        new_word = wdata;
        rdata    = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_responder.sv
// Data-memory responder: clears RAM after reset, then serves
// word/half/byte loads and stores with fixed wait states.
module dm_bus_responder
  import dm_bus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_align,
  input  logic        req_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  dm_state_t   state;
  logic [AW-1:0] clear_ptr;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_align;
  logic        lat_sign;

  logic [31:0] ram [DEPTH_WORDS];

  logic        in_idle;
  logic        commit;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_align;
  logic        cur_sign;
  logic        cur_err;
  logic [AW-1:0] widx;
  logic [31:0] old_word;
  logic [31:0] new_word;
  logic [31:0] lane_rdata;

  assign in_idle   = (state == ST_IDLE);
  assign req_ready = in_idle;

  // zero-wait commits straight from the bus, otherwise from latches
  assign cur_we    = in_idle ? req_we    : lat_we;
  assign cur_addr  = in_idle ? req_addr  : lat_addr;
  assign cur_wdata = in_idle ? req_wdata : lat_wdata;
  assign cur_align = in_idle ? req_align : lat_align;
  assign cur_sign  = in_idle ? req_sign  : lat_sign;

  assign commit = (in_idle && req_valid && WAIT_CYCLES == 0) ||
                  (state == ST_WAIT && cnt == 4'd1);

  assign cur_err = (cur_align == 2'b11) ||
                   (cur_align == DM_ALIGN_HALF && cur_addr[0]) ||
                   (cur_align == DM_ALIGN_WORD && cur_addr[1:0] != 2'b00) ||
                   (cur_addr >= LIMIT);

  assign widx     = cur_addr[AW+1:2];
  assign old_word = ram[widx];

  dm_lane_unit u_lane (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .addr_lo  (cur_addr[1:0]),
    .align    (cur_align),
    .sign     (cur_sign),
    .new_word (new_word),
    .rdata    (lane_rdata)
  );

  // RAM port: sweep zeros during clear, else committed stores
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      ram[clear_ptr] <= '0;
    else if (commit && cur_we && !cur_err)
      ram[widx] <= new_word;
  end

  // control FSM with registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clear_ptr  <= '0;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_align  <= '0;
      lat_sign   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == AW'(DEPTH_WORDS - 1))
            state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_align <= req_align;
            lat_sign  <= req_sign;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= ST_WAIT;
            if (commit) begin
              resp_valid <= 1'b1;
              resp_err   <= cur_err;
              resp_rdata <= (cur_err || cur_we) ? '0 : lane_rdata;
              state      <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (commit) begin
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            resp_rdata <= (cur_err || cur_we) ? '0 : lane_rdata;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
